// File: rtl/tk2000_clk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tk2000_clk_pkg
// Description : Shared clocking/reset types and default constants for the
//               TK2000 core clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
package tk2000_clk_pkg;

    // Reset sequencer state; encodings are visible on the debug port.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } rstseq_state_t;

    // System clock is PLL output 0.
    localparam int SYS_CLK_HZ     = 28571428;
    // 28.571428 MHz / 2  = 14.285714 MHz pixel enable.
    localparam int CE_DIV_PIX_DEF = 2;
    // 28.571428 MHz / 28 = 1.0204 MHz CPU enable.
    localparam int CE_DIV_CPU_DEF = 28;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Single-bit multi-flop synchronizer for signals asynchronous
//               to clk. Asynchronous active-low reset clears the chain to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // A single flop gives no metastability protection.
    generate
        if (SYNC_STAGES < 2) begin : g_stage_check
            $error("sync_bit: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Qualifies the PLL lock flag, sequences the core reset and
//               generates the pixel/CPU clock enables and CPU phi0 from the
//               system clock. Every output is registered.
//               Optional macro PLL_RSTSEQ_LOSS_CNT_EN adds an 8-bit
//               saturating count of lock losses while running.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import tk2000_clk_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int CE_DIV_PIX         = CE_DIV_PIX_DEF,
    parameter int CE_DIV_CPU         = CE_DIV_CPU_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       reset_out,
    output logic       ce_pix,
    output logic       ce_cpu,
    output logic       phi0,
    output logic       ready,
    output logic [1:0] state_o
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values (minimum width 1 bit)
    // ------------------------------------------------------------------
    localparam int c_stab_w = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int c_hold_w = (RST_HOLD_CYCLES > 1)    ? $clog2(RST_HOLD_CYCLES)    : 1;
    localparam int c_pix_w  = (CE_DIV_PIX > 1)         ? $clog2(CE_DIV_PIX)         : 1;
    localparam int c_cpu_w  = (CE_DIV_CPU > 1)         ? $clog2(CE_DIV_CPU)         : 1;

    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_pix_w-1:0]  c_pix_last  = c_pix_w'(CE_DIV_PIX - 1);
    localparam logic [c_cpu_w-1:0]  c_cpu_last  = c_cpu_w'(CE_DIV_CPU - 1);
    localparam logic [c_cpu_w-1:0]  c_cpu_half  = c_cpu_w'(CE_DIV_CPU / 2);

    // ce_cpu must land on a ce_pix, which needs an integer ratio.
    generate
        if ((CE_DIV_CPU % CE_DIV_PIX) != 0) begin : g_div_ratio_check
            $error("pll_reset_sequencer: CE_DIV_CPU must be a multiple of CE_DIV_PIX");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic w_lock_s;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock_s)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    rstseq_state_t       r_state;
    rstseq_state_t       w_state_next;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [c_stab_w-1:0] w_stab_next;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_next;
    logic [c_pix_w-1:0]  r_pix_cnt;
    logic [c_pix_w-1:0]  w_pix_next;
    logic [c_cpu_w-1:0]  r_cpu_cnt;
    logic [c_cpu_w-1:0]  w_cpu_next;
    logic                w_run_next;

    // Next-state and qualification counters; lock loss outranks soft reset.
    always_comb begin
        w_state_next = r_state;
        w_stab_next  = r_stab_cnt;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_stab_next = '0;
                if (w_lock_s) begin
                    w_state_next = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_stab_cnt == c_stab_last) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = '0;
                end else begin
                    w_stab_next = r_stab_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                // A held soft request keeps the hold window from expiring.
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (soft_reset_req) begin
                    w_hold_next = '0;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (soft_reset_req) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = '0;
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
            end
        endcase
    end

    assign w_run_next = (w_state_next == ST_RUN);

    // Dividers: zero whenever the next cycle is in reset, zero again on the
    // first running cycle, then free-running wraps.
    always_comb begin
        w_pix_next = '0;
        w_cpu_next = '0;
        if (w_run_next && !reset_out) begin
            w_pix_next = (r_pix_cnt == c_pix_last) ? '0 : r_pix_cnt + 1'b1;
            w_cpu_next = (r_cpu_cnt == c_cpu_last) ? '0 : r_cpu_cnt + 1'b1;
        end
    end

    // State, counters and all outputs registered off the next-state view,
    // so reset_out/ready/enables line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT_LOCK;
            r_stab_cnt <= '0;
            r_hold_cnt <= '0;
            r_pix_cnt  <= '0;
            r_cpu_cnt  <= '0;
            reset_out  <= 1'b1;
            ready      <= 1'b0;
            ce_pix     <= 1'b0;
            ce_cpu     <= 1'b0;
            phi0       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_stab_cnt <= w_stab_next;
            r_hold_cnt <= w_hold_next;
            r_pix_cnt  <= w_pix_next;
            r_cpu_cnt  <= w_cpu_next;
            reset_out  <= !w_run_next;
            ready      <= w_run_next;
            ce_pix     <= w_run_next && (w_pix_next == c_pix_last);
            ce_cpu     <= w_run_next && (w_cpu_next == c_cpu_last);
            phi0       <= w_run_next && (w_cpu_next >= c_cpu_half);
        end
    end

    assign state_o = r_state;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    // Only a lock drop while running counts; soft resets never do.
    assign w_loss_evt = (r_state == ST_RUN) && !w_lock_s;

    // Saturating lock-loss counter, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire
